// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Load hits return data combinationally. Load misses refill a whole line
// word by word from the backing RAM. Stores are always written through
// and update the cached word only when the line is already present.
// Optional feature macro: DCACHE_STATS_EN adds the hit_count/miss_count outputs.
module data_cache #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned SETS           = 64,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [3:0]            req_byte_en,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_byte_en,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int unsigned OW    = $clog2(WORDS_PER_LINE);
   localparam int unsigned IW    = $clog2(SETS);
   localparam int unsigned TW    = 32 - 2 - OW - IW;
   localparam int unsigned LANES = DATA_WIDTH / 8;
   localparam logic [OW-1:0] CNT_LAST = OW'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      IDLE,
      REFILL,
      WRITE,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [OW-1:0]         cnt_q, cnt_d;
   logic [SETS-1:0]       valid_q;
   logic [TW-1:0]         tag_q  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

   logic [TW-1:0] req_tag;
   logic [IW-1:0] req_idx;
   logic [OW-1:0] req_word;
   logic          hit;

   logic refill_wr;
   logic refill_last;
   logic store_wr;
   logic hit_evt;
   logic miss_evt;

   assign req_tag  = req_addr[31 -: TW];
   assign req_idx  = req_addr[OW+2 +: IW];
   assign req_word = req_addr[2 +: OW];
   assign hit      = valid_q[req_idx] & (tag_q[req_idx] == req_tag);

   // Byte offset never selects anything: accesses are whole words.
   logic unused_addr;
   assign unused_addr = ^req_addr[1:0];

   assign rdata = rst ? data_q[req_idx][req_word] : '0;

   // Next-state and backing-RAM handshake; everything is held quiet during reset.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall       = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_byte_en = '0;
      refill_wr   = 1'b0;
      refill_last = 1'b0;
      store_wr    = 1'b0;
      hit_evt     = 1'b0;
      miss_evt    = 1'b0;
      if (rst) begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  if (req_we) begin
                     stall   = 1'b1;
                     state_d = WRITE;
                  end else if (!hit) begin
                     stall    = 1'b1;
                     state_d  = REFILL;
                     cnt_d    = '0;
                     miss_evt = 1'b1;
                  end else begin
                     hit_evt = 1'b1;
                  end
               end
            end
            REFILL: begin
               stall    = 1'b1;
               mem_req  = 1'b1;
               mem_addr = {req_addr[31:OW+2], cnt_q, 2'b00};
               if (mem_ack) begin
                  refill_wr = 1'b1;
                  cnt_d     = cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     refill_last = 1'b1;
                     state_d     = IDLE;
                  end
               end
            end
            WRITE: begin
               stall       = 1'b1;
               mem_req     = 1'b1;
               mem_we      = 1'b1;
               mem_addr    = {req_addr[31:2], 2'b00};
               mem_wdata   = req_wdata;
               mem_byte_en = req_byte_en;
               if (mem_ack) begin
                  store_wr = hit;
                  state_d  = DONE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Control state: FSM, refill counter and line valid bits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (refill_last) begin
            valid_q[req_idx] <= 1'b1;
         end
      end
   end

   // Tag and data storage; not reset, only ever read behind a valid bit.
   always_ff @(posedge clk) begin
      if (refill_wr) begin
         data_q[req_idx][cnt_q] <= mem_rdata;
      end
      if (refill_last) begin
         tag_q[req_idx] <= req_tag;
      end
      if (store_wr) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (req_byte_en[i]) begin
               data_q[req_idx][req_word][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_q;
   logic [31:0] miss_q;

   // Hit/miss statistics, free-running and wrapping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (hit_evt) begin
            hit_q <= hit_q + 32'd1;
         end
         if (miss_evt) begin
            miss_q <= miss_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   logic unused_stats;
   assign unused_stats = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed + randomized bench for data_cache against a
// line-level cache model and a word-addressed expected memory image.
module tb_data_cache;

   localparam int unsigned SETS       = 64;
   localparam int unsigned WPL        = 4;
   localparam int unsigned LINE_BYTES = WPL * 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_byte_en;
   logic [31:0] rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_en;
   logic        mem_ack;
   logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   always #5 clk = ~clk;

   data_cache #(
      .DATA_WIDTH    (32),
      .SETS          (SETS),
      .WORDS_PER_LINE(WPL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_byte_en(req_byte_en),
      .rdata      (rdata),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_byte_en(mem_byte_en),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Backing RAM (driven by the DUT) and expected memory image (driven by the stimulus).
   logic [31:0] ram     [logic [31:0]];
   logic [31:0] exp_mem [logic [31:0]];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] ram_read(input logic [31:0] a);
      logic [31:0] k = {a[31:2], 2'b00};
      if (ram.exists(k)) return ram[k];
      return init_word(k);
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      logic [31:0] k = {a[31:2], 2'b00};
      if (exp_mem.exists(k)) return exp_mem[k];
      return init_word(k);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // Line-level cache model.
   bit          mvalid [SETS];
   int unsigned mtag   [SETS];
   int unsigned exp_hits;
   int unsigned exp_misses;

   function automatic int unsigned set_of(input logic [31:0] a);
      return (a / LINE_BYTES) % SETS;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] a);
      return a / (LINE_BYTES * SETS);
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      return mvalid[set_of(a)] && (mtag[set_of(a)] == tag_of(a));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
      check({tag, "_hits"}, hit_count, exp_hits);
      check({tag, "_misses"}, miss_count, exp_misses);
`else
      if (tag.len() == 0) $display("note: empty stats tag");
`endif
   endtask

   // Backing-RAM responder: random ack latency, stray acks, stability checks.
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [31:0] prev_addr, prev_wdata;
   logic [4:0]  prev_ctl;
   logic        pend_wr = 1'b0;
   logic [31:0] pend_a, pend_d;
   logic [3:0]  pend_be;

   initial begin
      logic ack;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         if (pend_wr) begin
            ram[pend_a] = merge(ram_read(pend_a), pend_d, pend_be);
            pend_wr = 1'b0;
         end
         #2;
         if (rst && prev_req && !prev_ack) begin
            check("mem_req_hold", mem_req, 1);
            check("mem_addr_stable", mem_addr, prev_addr);
            check("mem_wdata_stable", mem_wdata, prev_wdata);
            check("mem_ctl_stable", {mem_we, mem_byte_en}, prev_ctl);
         end
         if (rst && mem_req) ack = ($urandom_range(0, 2) != 0);
         else                ack = rst && ($urandom_range(0, 7) == 0);
         mem_ack   = ack;
         mem_rdata = (ack && mem_req && !mem_we) ? ram_read(mem_addr) : $urandom;
         if (ack && mem_req && mem_we) begin
            pend_wr = 1'b1;
            pend_a  = {mem_addr[31:2], 2'b00};
            pend_d  = mem_wdata;
            pend_be = mem_byte_en;
         end
         prev_req   = mem_req;
         prev_ack   = ack;
         prev_addr  = mem_addr;
         prev_wdata = mem_wdata;
         prev_ctl   = {mem_we, mem_byte_en};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b0;
      req_valid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         check("rst_stall", stall, 0);
         check("rst_mem_req", mem_req, 0);
         check("rst_rdata", rdata, 0);
         tick();
      end
      rst = 1'b1;
      model_reset();
   endtask

   task automatic do_idle(input int n);
      req_valid = 1'b0;
      req_addr  = $urandom;
      repeat (n) begin
         @(negedge clk);
         check("idle_stall", stall, 0);
         check("idle_mem_req", mem_req, 0);
         tick();
      end
   endtask

   // Runs the refill ack loop for a load already presented; stops after max_acks.
   task automatic refill_acks(input logic [31:0] addr, input int max_acks, output int k);
      logic [31:0] base = addr / LINE_BYTES * LINE_BYTES;
      int cyc = 0;
      k = 0;
      while (k < max_acks && cyc < 200) begin
         @(negedge clk);
         check("refill_stall", stall, 1);
         check("refill_mem_req", mem_req, 1);
         if (mem_ack) begin
            check("refill_we", mem_we, 0);
            check("refill_addr", mem_addr, base + 4 * k);
            k++;
         end
         tick();
         cyc++;
      end
      if (k < max_acks) check("refill_timeout", k, max_acks);
   endtask

   task automatic do_load(input logic [31:0] addr);
      logic [31:0] exp = exp_read(addr);
      int k;
      req_valid   = 1'b1;
      req_we      = 1'b0;
      req_addr    = addr;
      req_wdata   = $urandom;
      req_byte_en = 4'($urandom);
      @(negedge clk);
      if (model_hit(addr)) begin
         check_stats("hit");
         check("ld_hit_stall", stall, 0);
         check("ld_hit_rdata", rdata, exp);
         check("ld_hit_mem_req", mem_req, 0);
         exp_hits++;
         tick();
      end else begin
         check("ld_miss_stall", stall, 1);
         check("ld_miss_mem_req", mem_req, 0);
         exp_misses++;
         tick();
         refill_acks(addr, WPL, k);
         mvalid[set_of(addr)] = 1'b1;
         mtag[set_of(addr)]   = tag_of(addr);
         @(negedge clk);
         check_stats("post_refill");
         check("retry_stall", stall, 0);
         check("retry_rdata", rdata, exp);
         check("retry_mem_req", mem_req, 0);
         exp_hits++;
         tick();
      end
      req_valid = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
      int  cyc  = 0;
      bit  done = 1'b0;
      req_valid   = 1'b1;
      req_we      = 1'b1;
      req_addr    = addr;
      req_wdata   = d;
      req_byte_en = be;
      @(negedge clk);
      check("st_stall", stall, 1);
      check("st_mem_req_idle", mem_req, 0);
      tick();
      while (!done && cyc < 200) begin
         @(negedge clk);
         check("st_wait_stall", stall, 1);
         check("st_mem_req", mem_req, 1);
         check("st_mem_we", mem_we, 1);
         check("st_mem_addr", mem_addr, {addr[31:2], 2'b00});
         check("st_mem_wdata", mem_wdata, d);
         check("st_mem_be", mem_byte_en, be);
         done = mem_ack;
         tick();
         cyc++;
      end
      if (!done) check("st_timeout", 0, 1);
      exp_mem[{addr[31:2], 2'b00}] = merge(exp_read(addr), d, be);
      @(negedge clk);
      check("done_stall", stall, 0);
      check("done_mem_req", mem_req, 0);
      check("done_mem_be", mem_byte_en, 0);
      tick();
      req_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned t = $urandom_range(0, 3);
      int unsigned s = $urandom_range(0, 3);
      int unsigned w = $urandom_range(0, WPL - 1);
      return t * LINE_BYTES * SETS + s * LINE_BYTES + w * 4 + $urandom_range(0, 3);
   endfunction

   initial begin
      int k;
      logic [31:0] old104;
      rst         = 1'b0;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      req_byte_en = '0;
      model_reset();

      do_reset(2);
      do_load(32'h100);
      do_load(32'h108);
      old104 = exp_read(32'h104);
      do_store(32'h104, 32'hDEADBEEF, 4'b0011);
      check("store_merge_model", exp_read(32'h104), {old104[31:16], 16'hBEEF});
      do_load(32'h104);
      do_store(32'h2000, 32'h12345678, 4'b1111);
      do_load(32'h2000);
      do_load(32'h100);
      do_load(32'h100 + SETS * WPL * 4);
      do_load(32'h100);
      do_idle(3);

      for (int i = 0; i < 300; i++) begin
         int unsigned op = $urandom_range(0, 9);
         if (op < 6)      do_load(rand_addr());
         else if (op < 9) do_store(rand_addr(), $urandom, 4'($urandom));
         else             do_idle($urandom_range(1, 3));
      end

      // Reset in the middle of a refill, after its second ack.
      do_reset(1);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h100;
      @(negedge clk);
      check("abort_first_stall", stall, 1);
      tick();
      refill_acks(32'h100, 2, k);
      rst = 1'b0;
      @(negedge clk);
      check("abort_stall", stall, 0);
      check("abort_mem_req", mem_req, 0);
      check("abort_rdata", rdata, 0);
      tick();
      @(negedge clk);
      check("abort_next_mem_req", mem_req, 0);
      tick();
      rst       = 1'b1;
      req_valid = 1'b0;
      model_reset();
      do_load(32'h100);
      do_load(32'h104);
      do_idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
